// File: rtl/riscv_ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding and operand selection.
// Also raises the load-use stall and turns flushed/stalled slots into bubbles.
module riscv_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic [4:0]      i_id_rd_addr,
  input  logic [3:0]      i_id_alu_ctrl,
  input  logic            i_id_alu_src_a,
  input  logic            i_id_alu_src_b,
  input  logic            i_id_zero_condition,
  input  logic            i_id_reg_write,
  input  logic            i_id_mem_write,
  input  logic            i_id_branch,
  input  logic            i_id_jump,
  input  logic [1:0]      i_id_result_src,
  input  logic            i_mem_reg_write,
  input  logic [4:0]      i_mem_rd_addr,
  input  logic [XLEN-1:0] i_mem_alu_result,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic [XLEN-1:0] i_wb_result,
  input  logic            i_flush_e,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_zero_condition,
  output logic [XLEN-1:0] o_ex_write_data,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_rd_addr,
  output logic            o_ex_reg_write,
  output logic            o_ex_mem_write,
  output logic            o_ex_branch,
  output logic            o_ex_jump,
  output logic            o_ex_valid,
  output logic [1:0]      o_ex_result_src,
  output logic            o_stall_fd
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctrl;
    logic            src_a;
    logic            src_b;
    logic            zero_cond;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
  } id_ex_t;

  id_ex_t id_d;
  id_ex_t ex_q;

  logic            rs_hit;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  always_comb begin
    id_d            = '0;
    id_d.valid      = i_id_valid;
    id_d.pc         = i_id_pc;
    id_d.rs1_data   = i_id_rs1_data;
    id_d.rs2_data   = i_id_rs2_data;
    id_d.imm        = i_id_imm;
    id_d.rs1        = i_id_rs1_addr;
    id_d.rs2        = i_id_rs2_addr;
    id_d.rd         = i_id_rd_addr;
    id_d.alu_ctrl   = i_id_alu_ctrl;
    id_d.src_a      = i_id_alu_src_a;
    id_d.src_b      = i_id_alu_src_b;
    id_d.zero_cond  = i_id_zero_condition;
    id_d.reg_write  = i_id_reg_write;
    id_d.mem_write  = i_id_mem_write;
    id_d.branch     = i_id_branch;
    id_d.jump       = i_id_jump;
    id_d.result_src = i_id_result_src;
  end

  // Load in EX whose rd is read by the instruction in ID.
  assign rs_hit = (i_id_rs1_addr == ex_q.rd)
                | (i_id_rs2_addr == ex_q.rd);

  assign o_stall_fd = ex_q.valid
                    & (ex_q.result_src == 2'b01)
                    & (ex_q.rd != 5'd0)
                    & i_id_valid
                    & rs_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      ex_q <= '0;
    else if (i_flush_e || o_stall_fd)
      ex_q <= '0;
    else
      ex_q <= id_d;
  end

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf
  );
    logic mem_hit;
    logic wb_hit;
    mem_hit = FWD_EN & i_mem_reg_write
            & (i_mem_rd_addr != 5'd0)
            & (i_mem_rd_addr == idx);
    wb_hit  = FWD_EN & i_wb_reg_write
            & (i_wb_rd_addr != 5'd0)
            & (i_wb_rd_addr == idx);
    if (mem_hit)     return i_mem_alu_result;
    else if (wb_hit) return i_wb_result;
    else             return rf;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_sel(ex_q.rs1, ex_q.rs1_data);
    fwd_rs2 = fwd_sel(ex_q.rs2, ex_q.rs2_data);
  end

  assign o_alu_a          = ex_q.src_a ? ex_q.pc  : fwd_rs1;
  assign o_alu_b          = ex_q.src_b ? ex_q.imm : fwd_rs2;
  assign o_ex_write_data  = fwd_rs2;
  assign o_alu_ctrl       = ex_q.alu_ctrl;
  assign o_zero_condition = ex_q.zero_cond;
  assign o_ex_pc          = ex_q.pc;
  assign o_ex_imm         = ex_q.imm;
  assign o_ex_rd_addr     = ex_q.rd;
  assign o_ex_reg_write   = ex_q.reg_write;
  assign o_ex_mem_write   = ex_q.mem_write;
  assign o_ex_branch      = ex_q.branch;
  assign o_ex_jump        = ex_q.jump;
  assign o_ex_valid       = ex_q.valid;
  assign o_ex_result_src  = ex_q.result_src;

endmodule

// File: tb/tb_riscv_ex_operand_stage.sv
// Scoreboard bench for riscv_ex_operand_stage.
// Expected EX outputs are queued as ID stimulus is driven.
module tb_riscv_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [3:0]  id_ctrl = '0;
  logic        id_sa = 0, id_sb = 0, id_zc = 0;
  logic        id_rw = 0, id_mw = 0, id_br = 0, id_jp = 0;
  logic [1:0]  id_rs = '0;
  logic        mem_rw = 0, wb_rw = 0;
  logic [4:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_res = '0, wb_res = '0;
  logic        flush = 0;

  logic [31:0] alu_a, alu_b, wdata, ex_pc, ex_imm;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_rs;
  logic        zc, ex_rw, ex_mw, ex_br, ex_jp, ex_valid, stall;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        zc;
    logic        valid;
    logic        rw;
    logic        mw;
    logic        br;
    logic        jp;
    logic [1:0]  rs;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o, got_o;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  riscv_ex_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_pc(id_pc), .i_id_rs1_data(id_rs1_data),
    .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
    .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
    .i_id_rd_addr(id_rd), .i_id_alu_ctrl(id_ctrl),
    .i_id_alu_src_a(id_sa), .i_id_alu_src_b(id_sb),
    .i_id_zero_condition(id_zc), .i_id_reg_write(id_rw),
    .i_id_mem_write(id_mw), .i_id_branch(id_br),
    .i_id_jump(id_jp), .i_id_result_src(id_rs),
    .i_mem_reg_write(mem_rw), .i_mem_rd_addr(mem_rd),
    .i_mem_alu_result(mem_res), .i_wb_reg_write(wb_rw),
    .i_wb_rd_addr(wb_rd), .i_wb_result(wb_res),
    .i_flush_e(flush), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_alu_ctrl(alu_ctrl), .o_zero_condition(zc),
    .o_ex_write_data(wdata), .o_ex_pc(ex_pc),
    .o_ex_imm(ex_imm), .o_ex_rd_addr(ex_rd),
    .o_ex_reg_write(ex_rw), .o_ex_mem_write(ex_mw),
    .o_ex_branch(ex_br), .o_ex_jump(ex_jp),
    .o_ex_valid(ex_valid), .o_ex_result_src(ex_rs),
    .o_stall_fd(stall)
  );

  function automatic obs_t sample();
    obs_t o;
    o.alu_a = alu_a; o.alu_b = alu_b; o.wdata = wdata;
    o.pc = ex_pc; o.imm = ex_imm; o.rd = ex_rd;
    o.ctrl = alu_ctrl; o.zc = zc; o.valid = ex_valid;
    o.rw = ex_rw; o.mw = ex_mw; o.br = ex_br;
    o.jp = ex_jp; o.rs = ex_rs;
    return o;
  endfunction

  function automatic obs_t mk(
    input logic [31:0] a, b, wd, pc, imm,
    input logic [4:0] rd, input logic [3:0] ctrl,
    input logic zc_, v, rw, mw, br, jp,
    input logic [1:0] rs
  );
    obs_t o;
    o.alu_a = a; o.alu_b = b; o.wdata = wd;
    o.pc = pc; o.imm = imm; o.rd = rd; o.ctrl = ctrl;
    o.zc = zc_; o.valid = v; o.rw = rw; o.mw = mw;
    o.br = br; o.jp = jp; o.rs = rs;
    return o;
  endfunction

  task automatic drive(
    input logic v, input logic [31:0] pc, d1, d2, imm,
    input logic [4:0] r1, r2, rd, input logic [3:0] ctrl,
    input logic sa, sbs, z, rw, mw, br, jp,
    input logic [1:0] rs
  );
    id_valid = v; id_pc = pc; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_rs1 = r1;
    id_rs2 = r2; id_rd = rd; id_ctrl = ctrl; id_sa = sa;
    id_sb = sbs; id_zc = z; id_rw = rw; id_mw = mw;
    id_br = br; id_jp = jp; id_rs = rs;
  endtask

  task automatic clear_fwd();
    mem_rw = 0; wb_rw = 0; mem_rd = '0; wb_rd = '0;
    mem_res = '0; wb_res = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h40, 32'd5, 32'd7, 32'h123, 5'd1, 5'd2,
          5'd3, 4'h0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL reset_regs got=%h exp=%h", got_o, exp_o);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall got=%b exp=0", stall);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(mk(32'd5, 32'd7, 32'd7, 32'h40, 32'h123,
                    5'd3, 4'h0, 0, 1, 1, 0, 0, 0, 2'b00));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL first_after_reset got=%h exp=%h",
               got_o, exp_o);
    end
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    drive(1, 32'h80, 32'hA, 32'hB, 32'h10, 5'd6, 5'd7,
          5'd0, 4'h1, 0, 0, 1, 0, 0, 1, 0, 2'b00);
    sb.push_back(mk(32'hA, 32'hB, 32'hB, 32'h80, 32'h10,
                    5'd0, 4'h1, 1, 1, 0, 0, 1, 0, 2'b00));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL pass_branch got=%h exp=%h", got_o, exp_o);
    end
    @(negedge clk);
    drive(1, 32'h84, 32'h1, 32'h2, 32'h30, 5'd1, 5'd2,
          5'd1, 4'h0, 1, 1, 0, 1, 0, 0, 1, 2'b10);
    sb.push_back(mk(32'h84, 32'h30, 32'h2, 32'h84, 32'h30,
                    5'd1, 4'h0, 0, 1, 1, 0, 0, 1, 2'b10));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL pass_jal got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive(1, 32'h90, 32'h33, 32'h44, 32'h0, 5'd4, 5'd9,
          5'd8, 4'h0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    mem_rw = 1; mem_rd = 5'd4; mem_res = 32'h11;
    wb_rw = 1;  wb_rd = 5'd4;  wb_res = 32'h22;
    #1;
    checks++;
    if (alu_a !== 32'h11) begin
      errors++;
      $display("FAIL fwd_mem_over_wb got=%h exp=11", alu_a);
    end
    mem_rw = 0;
    #1;
    checks++;
    if (alu_a !== 32'h22) begin
      errors++;
      $display("FAIL fwd_wb got=%h exp=22", alu_a);
    end
    mem_rw = 1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++;
    if (alu_a !== 32'h33) begin
      errors++;
      $display("FAIL fwd_x0 got=%h exp=33", alu_a);
    end
    mem_rd = 5'd9; mem_res = 32'h55;
    wb_rd = 5'd9;  wb_res = 32'h66;
    #1;
    checks++;
    if ({alu_b, wdata, alu_a} !== {32'h55, 32'h55, 32'h33}) begin
      errors++;
      $display("FAIL fwd_rs2 got=%h/%h/%h exp=55/55/33",
               alu_b, wdata, alu_a);
    end
    clear_fwd();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1, 32'h200, 32'h100, 32'h0, 32'h4, 5'd1, 5'd0,
          5'd5, 4'h0, 0, 1, 0, 1, 0, 0, 0, 2'b01);
    sb.push_back(mk(32'h100, 32'h4, 32'h0, 32'h200, 32'h4,
                    5'd5, 4'h0, 0, 1, 1, 0, 0, 0, 2'b01));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL lw_load got=%h exp=%h", got_o, exp_o);
    end
    @(negedge clk);
    drive(1, 32'h204, 32'h3, 32'h9, 32'h0, 5'd1, 5'd5,
          5'd6, 4'h0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got=%b exp=1", stall);
    end
    sb.push_back('0);
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL lu_bubble got=%h exp=%h", got_o, exp_o);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_clear got=%b exp=0", stall);
    end
    sb.push_back(mk(32'h3, 32'h9, 32'h9, 32'h204, 32'h0,
                    5'd6, 4'h0, 0, 1, 1, 0, 0, 0, 2'b00));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL lu_replay got=%h exp=%h", got_o, exp_o);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1, 32'h300, 32'h50, 32'h60, 32'h8, 5'd2, 5'd3,
          5'd0, 4'h0, 0, 1, 0, 0, 1, 0, 0, 2'b00);
    flush = 1;
    sb.push_back('0);
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL flush_sw got=%h exp=%h", got_o, exp_o);
    end
    @(negedge clk);
    flush = 0;
    drive(1, 32'h304, 32'h20, 32'h0, 32'h0, 5'd2, 5'd0,
          5'd7, 4'h0, 0, 1, 0, 1, 0, 0, 0, 2'b01);
    sb.push_back(mk(32'h20, 32'h0, 32'h0, 32'h304, 32'h0,
                    5'd7, 4'h0, 0, 1, 1, 0, 0, 0, 2'b01));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL flush_lw got=%h exp=%h", got_o, exp_o);
    end
    @(negedge clk);
    drive(1, 32'h308, 32'h50, 32'h60, 32'h8, 5'd2, 5'd7,
          5'd0, 4'h0, 0, 1, 0, 0, 1, 0, 0, 2'b00);
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_drv got=%b exp=1", stall);
    end
    sb.push_back('0);
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL flush_and_stall got=%h exp=%h",
               got_o, exp_o);
    end
    @(negedge clk);
    flush = 0;
  endtask

  task automatic test_auipc();
    @(negedge clk);
    drive(1, 32'h100, 32'h0, 32'h77, 32'h2000, 5'd0, 5'd10,
          5'd11, 4'h0, 1, 1, 0, 1, 0, 0, 0, 2'b00);
    sb.push_back(mk(32'h100, 32'h2000, 32'h77, 32'h100,
                    32'h2000, 5'd11, 4'h0, 0, 1, 1, 0, 0, 0,
                    2'b00));
    @(posedge clk); #1;
    exp_o = sb.pop_front(); got_o = sample();
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL auipc got=%h exp=%h", got_o, exp_o);
    end
    mem_rw = 1; mem_rd = 5'd10; mem_res = 32'hABCD;
    #1;
    checks++;
    if ({alu_a, alu_b, wdata}
        !== {32'h100, 32'h2000, 32'hABCD}) begin
      errors++;
      $display("FAIL auipc_fwd got=%h/%h/%h exp=100/2000/abcd",
               alu_a, alu_b, wdata);
    end
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 32'h1000 + 32'(i);
      b = 32'h2000 + 32'(i * 3);
      drive(1, 32'h400 + 32'(i * 4), a, b, 32'(i), 5'd1,
            5'd2, 5'(12 + i), 4'(i), 0, 0, 0, 1, 0, 0, 0,
            2'b00);
      sb.push_back(mk(a, b, b, 32'h400 + 32'(i * 4), 32'(i),
                      5'(12 + i), 4'(i), 0, 1, 1, 0, 0, 0,
                      2'b00));
      @(posedge clk); #1;
      exp_o = sb.pop_front(); got_o = sample();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, got_o, exp_o);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive(1, 32'h500, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0,
          5'd9, 4'h0, 0, 1, 0, 1, 0, 0, 0, 2'b01);
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h504, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0,
          5'd10, 4'h0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rms_stall got=%b exp=1", stall);
    end
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, stall} !== 2'b00) begin
      errors++;
      $display("FAIL rms_clear got=%b%b exp=00", ex_valid, stall);
    end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_forward();
    test_load_use();
    test_flush();
    test_auipc();
    test_back_to_back();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
